// File: rtl/vc_req_latency_tracker_pkg.sv
// Shared definitions for the vcache request latency tracker.
//   vc_ts_width_gp   : width of cycle timestamps and latencies
//   rec_state_e      : occupancy of the one-entry record output register
//   elapsed_cycles() : wrap-safe difference between two timestamps
// The record struct (vc_latency_rec_s) and the packet structs depend on
// coordinate/address widths, so they are declared in the top module.
package vc_req_latency_tracker_pkg;

  localparam int vc_ts_width_gp = 32;

  typedef enum logic {
    eRecEmpty = 1'b0,
    eRecFull  = 1'b1
  } rec_state_e;

  // Unsigned modulo-2^32 subtraction; a counter wrap between request and
  // return still yields the true cycle distance.
  function automatic logic [vc_ts_width_gp-1:0] elapsed_cycles(
    input logic [vc_ts_width_gp-1:0] now_cycle,
    input logic [vc_ts_width_gp-1:0] start_cycle
  );
    return now_cycle - start_cycle;
  endfunction

endpackage

// File: rtl/vc_req_latency_fifo.sv
// Outstanding-request FIFO: holds {timestamp, src_x, src_y} for every
// forward request until its in-order return arrives.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   v_i, data_i    : write an entry (caller guarantees room, or a same-cycle pop)
//   yumi_i         : retire the head entry (caller guarantees non-empty)
//   data_o         : head entry
//   full_o/empty_o : occupancy flags derived from the 0..els_p count
module vc_req_latency_fifo
  import vc_req_latency_tracker_pkg::*;
#(
  parameter int width_p = 40,
  parameter int els_p   = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam logic [ptr_w_lp-1:0] ptr_one_lp  = (ptr_w_lp)'(1);
  localparam logic [ptr_w_lp:0]   cnt_one_lp  = (ptr_w_lp+1)'(1);
  localparam logic [ptr_w_lp:0]   cnt_full_lp = (ptr_w_lp+1)'(els_p);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [ptr_w_lp:0]   count_r;

  // Pointers wrap naturally because els_p is a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (v_i)    wptr_r <= wptr_r + ptr_one_lp;
      if (yumi_i) rptr_r <= rptr_r + ptr_one_lp;
      case ({v_i, yumi_i})
        2'b10:   count_r <= count_r + cnt_one_lp;
        2'b01:   count_r <= count_r - cnt_one_lp;
        default: count_r <= count_r;
      endcase
    end
  end

  // When full with a same-cycle pop, wptr == rptr: the head is read this
  // cycle before the new entry overwrites that slot.
  always_ff @(posedge clk_i) begin
    if (v_i) mem_r[wptr_r] <= data_i;
  end

  assign data_o  = mem_r[rptr_r];
  assign full_o  = (count_r == cnt_full_lp);
  assign empty_o = (count_r == '0);

endmodule

// File: rtl/vc_req_latency_tracker.sv
// Latency monitor on the tile/vcache link. Every accepted forward request
// is timestamped; the next accepted return (the link returns in order) is
// matched against it and a {src_x, src_y, latency} record is offered on a
// one-entry valid/ready output. Records arriving while the output is held
// are counted in dropped_o. Sticky flags report overflow, underflow and
// return-coordinate mismatch until reset.
//   clk_i, reset_i                 : clock, asynchronous active-high reset
//   fwd_packet_i/fwd_v_i/fwd_yumi_i: forward request and its acceptance
//   ret_packet_i/ret_v_i/ret_ready_i: return packet and its acceptance
//   global_ctr_i                   : free-running cycle counter
//   rec_v_o/rec_ready_i            : record handshake
//   rec_src_x_o/rec_src_y_o/rec_latency_o : record fields
//   dropped_o                      : saturating count of discarded records
//   overflow_o/underflow_o/mismatch_o : sticky error flags
// Packet layout (MSB..LSB):
//   forward: {addr, payload, src_y_cord, src_x_cord, y_cord, x_cord}
//   return : {payload, y_cord, x_cord}
module vc_req_latency_tracker
  import vc_req_latency_tracker_pkg::*;
#(
  parameter int link_addr_width_p = 32,
  parameter int data_width_p      = 32,
  parameter int x_cord_width_p    = 7,
  parameter int y_cord_width_p    = 7,
  parameter int els_p             = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [link_addr_width_p+data_width_p+2*x_cord_width_p+2*y_cord_width_p-1:0] fwd_packet_i,
  input  logic                         fwd_v_i,
  input  logic                         fwd_yumi_i,
  input  logic [data_width_p+x_cord_width_p+y_cord_width_p-1:0] ret_packet_i,
  input  logic                         ret_v_i,
  input  logic                         ret_ready_i,
  input  logic [vc_ts_width_gp-1:0]    global_ctr_i,
  output logic                         rec_v_o,
  input  logic                         rec_ready_i,
  output logic [x_cord_width_p-1:0]    rec_src_x_o,
  output logic [y_cord_width_p-1:0]    rec_src_y_o,
  output logic [vc_ts_width_gp-1:0]    rec_latency_o,
  output logic [31:0]                  dropped_o,
  output logic                         overflow_o,
  output logic                         underflow_o,
  output logic                         mismatch_o
);

  typedef struct packed {
    logic [link_addr_width_p-1:0] addr;
    logic [data_width_p-1:0]      payload;
    logic [y_cord_width_p-1:0]    src_y_cord;
    logic [x_cord_width_p-1:0]    src_x_cord;
    logic [y_cord_width_p-1:0]    y_cord;
    logic [x_cord_width_p-1:0]    x_cord;
  } fwd_packet_s;

  typedef struct packed {
    logic [data_width_p-1:0]   payload;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } ret_packet_s;

  typedef struct packed {
    logic [x_cord_width_p-1:0] src_x;
    logic [y_cord_width_p-1:0] src_y;
    logic [vc_ts_width_gp-1:0] latency;
  } vc_latency_rec_s;

  typedef struct packed {
    logic [vc_ts_width_gp-1:0] ts;
    logic [x_cord_width_p-1:0] src_x;
    logic [y_cord_width_p-1:0] src_y;
  } fifo_entry_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  fwd_packet_s     fwd_pkt;
  ret_packet_s     ret_pkt;
  fifo_entry_s     push_entry, head_entry;
  logic            fifo_full, fifo_empty;
  logic            push_req, pop_req, push_ok;
  logic            overflow_evt, underflow_evt, mismatch_evt;
  logic            vld_p0;
  vc_latency_rec_s rec_p0, rec_p1;
  rec_state_e      rec_state_r, rec_state_n;
  logic            rec_load, rec_drop;
  logic [31:0]     dropped_r;
  logic            overflow_r, underflow_r, mismatch_r;
  logic            unused_fields;

  assign fwd_pkt = fwd_packet_i;
  assign ret_pkt = ret_packet_i;
  assign unused_fields = ^{fwd_pkt.addr, fwd_pkt.payload, fwd_pkt.y_cord,
                           fwd_pkt.x_cord, ret_pkt.payload};

  // ---- stage p0: request/return matching against the FIFO head ----
  assign push_req = fwd_v_i & fwd_yumi_i;
  assign pop_req  = ret_v_i & ret_ready_i;
  assign vld_p0   = pop_req & ~fifo_empty;
  // A full FIFO still accepts a push when the head retires the same cycle.
  assign push_ok  = push_req & (~fifo_full | vld_p0);

  assign overflow_evt  = push_req & fifo_full & ~vld_p0;
  assign underflow_evt = pop_req & fifo_empty;
  assign mismatch_evt  = vld_p0 & ((ret_pkt.x_cord != head_entry.src_x) |
                                   (ret_pkt.y_cord != head_entry.src_y));

  assign push_entry = '{ts: global_ctr_i,
                        src_x: fwd_pkt.src_x_cord,
                        src_y: fwd_pkt.src_y_cord};

  assign rec_p0 = '{src_x: head_entry.src_x,
                    src_y: head_entry.src_y,
                    latency: elapsed_cycles(global_ctr_i, head_entry.ts)};

  vc_req_latency_fifo #(
    .width_p ($bits(fifo_entry_s)),
    .els_p   (els_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (push_ok),
    .data_i  (push_entry),
    .yumi_i  (vld_p0),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rec_state_r <= eRecEmpty;
    else         rec_state_r <= rec_state_n;
  end

  // A held record is never overwritten: a new record only loads when the
  // register is empty or the consumer takes the current one this cycle.
  always_comb begin
    rec_state_n = rec_state_r;
    rec_load    = 1'b0;
    rec_drop    = 1'b0;
    case (rec_state_r)
      eRecEmpty: begin
        if (vld_p0) begin
          rec_state_n = eRecFull;
          rec_load    = 1'b1;
        end
      end
      eRecFull: begin
        if (rec_ready_i) begin
          rec_load = vld_p0;
          if (!vld_p0) rec_state_n = eRecEmpty;
        end else begin
          rec_drop = vld_p0;
        end
      end
      default: rec_state_n = eRecEmpty;
    endcase
  end

  // ---- stage p1: record output register and sticky status ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rec_p1      <= '0;
      dropped_r   <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      mismatch_r  <= 1'b0;
    end else begin
      if (rec_load) rec_p1 <= rec_p0;
      if (rec_drop) dropped_r <= sat_inc(dropped_r);
      overflow_r  <= overflow_r  | overflow_evt;
      underflow_r <= underflow_r | underflow_evt;
      mismatch_r  <= mismatch_r  | mismatch_evt;
    end
  end

  assign rec_v_o       = (rec_state_r == eRecFull);
  assign rec_src_x_o   = rec_p1.src_x;
  assign rec_src_y_o   = rec_p1.src_y;
  assign rec_latency_o = rec_p1.latency;
  assign dropped_o     = dropped_r;
  assign overflow_o    = overflow_r;
  assign underflow_o   = underflow_r;
  assign mismatch_o    = mismatch_r;

endmodule

// File: tb/tb_vc_req_latency_tracker.sv
// Randomised and directed bench for vc_req_latency_tracker with a
// queue-based reference model of outstanding requests and record output.
module tb_vc_req_latency_tracker;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int XW  = 4;
  localparam int YW  = 4;
  localparam int ELS = 16;
  localparam int FW  = AW + DW + 2*XW + 2*YW;
  localparam int RW  = DW + XW + YW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [FW-1:0] fwd_packet = '0;
  logic          fwd_v = 1'b0;
  logic          fwd_yumi = 1'b0;
  logic [RW-1:0] ret_packet = '0;
  logic          ret_v = 1'b0;
  logic          ret_ready = 1'b0;
  logic [31:0]   ctr = '0;
  logic          rec_ready = 1'b1;

  logic          rec_v_o;
  logic [XW-1:0] rec_src_x_o;
  logic [YW-1:0] rec_src_y_o;
  logic [31:0]   rec_latency_o;
  logic [31:0]   dropped_o;
  logic          overflow_o, underflow_o, mismatch_o;

  always #5 clk = ~clk;

  vc_req_latency_tracker #(
    .link_addr_width_p (AW),
    .data_width_p      (DW),
    .x_cord_width_p    (XW),
    .y_cord_width_p    (YW),
    .els_p             (ELS)
  ) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .fwd_packet_i  (fwd_packet),
    .fwd_v_i       (fwd_v),
    .fwd_yumi_i    (fwd_yumi),
    .ret_packet_i  (ret_packet),
    .ret_v_i       (ret_v),
    .ret_ready_i   (ret_ready),
    .global_ctr_i  (ctr),
    .rec_v_o       (rec_v_o),
    .rec_ready_i   (rec_ready),
    .rec_src_x_o   (rec_src_x_o),
    .rec_src_y_o   (rec_src_y_o),
    .rec_latency_o (rec_latency_o),
    .dropped_o     (dropped_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o),
    .mismatch_o    (mismatch_o)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]   ts;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } ent_t;

  ent_t          q[$];
  logic          m_v;
  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [31:0]   m_lat, m_drop;
  logic          m_ovf, m_unf, m_mis;
  int            total = 0;
  int            bad = 0;

  task automatic model_reset();
    q.delete();
    m_v = 1'b0; m_x = '0; m_y = '0; m_lat = '0; m_drop = '0;
    m_ovf = 1'b0; m_unf = 1'b0; m_mis = 1'b0;
  endtask

  // Applied at each rising edge with the inputs the DUT samples there.
  // The return is resolved before the push, so a full queue with a
  // same-cycle return accepts the push and an empty one underflows.
  task automatic model_step();
    ent_t          e;
    logic          have;
    logic [31:0]   lat;
    logic [XW-1:0] rx;
    logic [YW-1:0] ry;
    if (rst) begin
      model_reset();
    end else begin
      have = 1'b0; lat = '0;
      e = '{ts: 32'd0, x: '0, y: '0};
      rx = ret_packet[XW-1:0];
      ry = ret_packet[XW+YW-1:XW];
      if (ret_v && ret_ready) begin
        if (q.size() == 0) m_unf = 1'b1;
        else begin
          e = q.pop_front();
          have = 1'b1;
          lat = ctr - e.ts;
          if (rx != e.x || ry != e.y) m_mis = 1'b1;
        end
      end
      if (fwd_v && fwd_yumi) begin
        if (q.size() < ELS)
          q.push_back('{ts: ctr, x: fwd_packet[2*XW+YW-1:XW+YW],
                        y: fwd_packet[2*XW+2*YW-1:2*XW+YW]});
        else m_ovf = 1'b1;
      end
      if (have) begin
        if (!m_v || rec_ready) begin
          m_v = 1'b1; m_x = e.x; m_y = e.y; m_lat = lat;
        end else if (m_drop != 32'hFFFF_FFFF) begin
          m_drop = m_drop + 32'd1;
        end
      end else if (m_v && rec_ready) begin
        m_v = 1'b0;
      end
    end
  endtask

  task automatic compare();
    total++;
    if (rec_v_o !== m_v || rec_src_x_o !== m_x || rec_src_y_o !== m_y ||
        rec_latency_o !== m_lat || dropped_o !== m_drop || overflow_o !== m_ovf ||
        underflow_o !== m_unf || mismatch_o !== m_mis) begin
      bad++;
      $display("FAIL outputs t=%0t actual v=%b x=%0d y=%0d lat=%0d drop=%0d ovf=%b unf=%b mis=%b required v=%b x=%0d y=%0d lat=%0d drop=%0d ovf=%b unf=%b mis=%b",
               $time, rec_v_o, rec_src_x_o, rec_src_y_o, rec_latency_o, dropped_o,
               overflow_o, underflow_o, mismatch_o, m_v, m_x, m_y, m_lat, m_drop,
               m_ovf, m_unf, m_mis);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [FW-1:0] mk_fwd(input logic [XW-1:0] sx, input logic [YW-1:0] sy);
    return {AW'($urandom), DW'($urandom), sy, sx, YW'($urandom), XW'($urandom)};
  endfunction

  function automatic logic [RW-1:0] mk_ret(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return {DW'($urandom), y, x};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    ctr = ctr + 32'd1;
  endtask

  task automatic idle();
    fwd_v = 1'b0; fwd_yumi = 1'b0; ret_v = 1'b0;
    cycle();
  endtask

  task automatic push(input logic [XW-1:0] sx, input logic [YW-1:0] sy);
    fwd_packet = mk_fwd(sx, sy); fwd_v = 1'b1; fwd_yumi = 1'b1; ret_v = 1'b0;
    cycle();
    fwd_v = 1'b0; fwd_yumi = 1'b0;
  endtask

  task automatic ret(input logic [XW-1:0] x, input logic [YW-1:0] y);
    ret_packet = mk_ret(x, y); ret_v = 1'b1; ret_ready = 1'b1;
    fwd_v = 1'b0; fwd_yumi = 1'b0;
    cycle();
    ret_v = 1'b0;
  endtask

  task automatic idle_until(input logic [31:0] target);
    for (int i = 0; i < 200 && ctr != target; i++) idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    @(negedge clk);
    do_reset();
    chk("reset_rec_v", 32'(rec_v_o), 32'd0);
    chk("reset_dropped", dropped_o, 32'd0);

    // Single request (1,2) at ctr=100, return at 117.
    rec_ready = 1'b1;
    ctr = 32'd100;
    push(4'd1, 4'd2);
    idle_until(32'd117);
    ret(4'd1, 4'd2);
    chk("single_ctr", ctr, 32'd118);
    chk("single_v", 32'(rec_v_o), 32'd1);
    chk("single_lat", rec_latency_o, 32'd17);
    chk("single_src", {28'd0, rec_src_y_o, rec_src_x_o}, 32'h21);
    chk("single_flags", {29'd0, overflow_o, underflow_o, mismatch_o}, 32'd0);
    idle();
    chk("single_drain", 32'(rec_v_o), 32'd0);

    // Back-to-back requests at 10,11,12; returns at 20,25,26.
    ctr = 32'd10;
    push(4'd3, 4'd1); push(4'd3, 4'd1); push(4'd3, 4'd1);
    idle_until(32'd20);
    ret(4'd3, 4'd1);
    chk("b2b_lat0", rec_latency_o, 32'd10);
    idle_until(32'd25);
    ret(4'd3, 4'd1);
    chk("b2b_lat1", rec_latency_o, 32'd14);
    ret(4'd3, 4'd1);
    chk("b2b_lat2", rec_latency_o, 32'd14);
    idle();

    // Backpressure: second record is dropped while the first is held.
    rec_ready = 1'b0;
    push(4'd5, 4'd6); push(4'd7, 4'd8);
    ret(4'd5, 4'd6);
    ret(4'd7, 4'd8);
    chk("bp_held_v", 32'(rec_v_o), 32'd1);
    chk("bp_held_lat", rec_latency_o, 32'd2);
    chk("bp_held_x", 32'(rec_src_x_o), 32'd5);
    chk("bp_dropped", dropped_o, 32'd1);
    rec_ready = 1'b1;
    idle();
    chk("bp_drain_v", 32'(rec_v_o), 32'd0);

    // Overflow at 17 pushes, then 16 returns drain and the 17th underflows.
    for (int i = 0; i < 16; i++) push(4'd2, 4'd2);
    chk("ovf_at_16", 32'(overflow_o), 32'd0);
    push(4'd2, 4'd2);
    chk("ovf_at_17", 32'(overflow_o), 32'd1);
    for (int i = 0; i < 16; i++) ret(4'd2, 4'd2);
    chk("unf_before", 32'(underflow_o), 32'd0);
    ret(4'd2, 4'd2);
    chk("unf_after", 32'(underflow_o), 32'd1);
    chk("unf_no_rec", 32'(rec_v_o), 32'd0);

    // Coordinate mismatch still yields the record with the stored source.
    do_reset();
    push(4'd0, 4'd3);
    ret(4'd0, 4'd4);
    chk("mis_flag", 32'(mismatch_o), 32'd1);
    chk("mis_v", 32'(rec_v_o), 32'd1);
    chk("mis_src", {28'd0, rec_src_y_o, rec_src_x_o}, 32'h30);

    // Counter wrap, then reset with four entries outstanding.
    do_reset();
    ctr = 32'hFFFF_FFF0;
    push(4'd9, 4'd9);
    ctr = 32'd5;
    ret(4'd9, 4'd9);
    chk("wrap_lat", rec_latency_o, 32'd21);
    rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'd1, 4'd1);
    chk("prerst_v", 32'(rec_v_o), 32'd1);
    do_reset();
    chk("rst_async_v", 32'(rec_v_o), 32'd0);
    rec_ready = 1'b1;
    ret(4'd1, 4'd1);
    chk("rst_unf", 32'(underflow_o), 32'd1);
    chk("rst_no_rec", 32'(rec_v_o), 32'd0);

    // Randomised traffic with alternating fill/drain bias.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int push_pct;
      int pop_pct;
      push_pct = ((i / 300) % 2 == 0) ? 60 : 25;
      pop_pct  = ((i / 300) % 2 == 0) ? 25 : 60;
      fwd_v      = ($urandom_range(0, 99) < push_pct);
      fwd_yumi   = ($urandom_range(0, 99) < 85);
      fwd_packet = mk_fwd(XW'($urandom), YW'($urandom));
      ret_v      = ($urandom_range(0, 99) < pop_pct);
      ret_ready  = ($urandom_range(0, 99) < 85);
      if (q.size() > 0 && $urandom_range(0, 9) != 0)
        ret_packet = mk_ret(q[0].x, q[0].y);
      else
        ret_packet = mk_ret(XW'($urandom), YW'($urandom));
      rec_ready  = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 199) == 0) ctr = $urandom;
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_req_latency_tracker.md
Name: vc_req_latency_tracker

Overview:
- Simulation-side monitor attached at the tile/vcache link boundary, on the forward (request) path directly upstream of the return-packet trace point.
- Timestamps every forward request accepted by the vcache link and matches it to the next accepted return packet; the link returns in order.
- Produces one latency record per matched pair on a valid/ready output consumed by a DPI logger.
- Flags overflow, underflow and coordinate-mismatch errors.

Parameters:
- link_addr_width_p, none (must be set), manycore packet address width.
- data_width_p, none (must be set), packet data width.
- x_cord_width_p, none (must be set), x coordinate width.
- y_cord_width_p, none (must be set), y coordinate width.
- els_p, 16, outstanding-request FIFO depth; power of two, ≥2.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- fwd_packet_i  in  bsg_manycore_packet_width  forward request packet
- fwd_v_i  in  1  forward packet valid
- fwd_yumi_i  in  1  forward packet consumed by link
- ret_packet_i  in  bsg_manycore_return_packet_width  return packet
- ret_v_i  in  1  return valid
- ret_ready_i  in  1  return accepted downstream
- global_ctr_i  in  32  free-running cycle counter
- rec_v_o  out  1  latency record valid
- rec_ready_i  in  1  consumer ready
- rec_src_x_o  out  x_cord_width_p  requesting tile x
- rec_src_y_o  out  y_cord_width_p  requesting tile y
- rec_latency_o  out  32  return cycle minus request cycle
- dropped_o  out  32  count of records lost to backpressure
- overflow_o  out  1  sticky: push while FIFO full
- underflow_o  out  1  sticky: return while FIFO empty
- mismatch_o  out  1  sticky: return destination differs from stored source

Behaviour:
- Push condition: fwd_v_i & fwd_yumi_i. Pop condition: ret_v_i & ret_ready_i. Both are sampled on posedge clk_i.
- FIFO entry: {global_ctr_i, src_x_cord, src_y_cord} taken from the forward packet.
- FIFO uses wrap-around read/write pointers and a count 0..els_p.
- Simultaneous push and pop:
  - When count > 0, both occur and count is unchanged.
  - When count == 0, the pop is an underflow: set underflow_o, produce no record, and the push still occurs.
- Push when count == els_p and no pop: drop the entry and set overflow_o.
- Push when count == els_p with a pop: legal.
- On a valid pop:
  - latency = global_ctr_i − stored timestamp, unsigned modulo 2^32, so counter wrap is handled.
  - If the return packet's x_cord/y_cord differ from the stored src: set mismatch_o; the record is still produced.
- Output register, one entry. Record state machine:
  - States: EMPTY and FULL, shown on rec_v_o.
  - EMPTY + valid pop → FULL, loaded with the record. Latency from the return cycle to rec_v_o is 1 cycle.
  - FULL + rec_ready_i and no new record → EMPTY.
  - FULL + rec_ready_i and a new record → stays FULL, loaded with the new record.
  - FULL + no rec_ready_i and a new record → the new record is discarded and dropped_o increments. dropped_o saturates at 2^32−1.
- Reset, asynchronous and effective immediately:
  - Pointers and count go to 0; the record state goes to EMPTY.
  - rec_v_o=0, rec_src_x_o/y_o=0, rec_latency_o=0, dropped_o=0; all sticky flags = 0.
  - Outstanding entries are discarded.
  - Returns arriving after reset for requests made before reset count as underflow.
- Sticky flags clear only on reset.

Decomposition:
- Shared package (bsg_manycore_pkg or a testbench-side trace package):
  - vc_latency_rec_s {src_x, src_y, latency}
  - Timestamp width constant, 32.
- The packet structs are cast locally via the standard declare macro.
- One sub-module: vc_req_latency_fifo, the timestamp/source FIFO with pointers, count, full and empty.
- The top level holds matching, error flags and the output register.

Test Plan:
- Single request from (1,2) accepted at ctr=100, return to (1,2) at ctr=117 → rec_v_o at ctr=118 with latency=17, src=(1,2); no flags set.
- Three back-to-back requests at ctr=10,11,12 and returns at 20,25,26 → records in order with latencies 10,14,14.
- Hold rec_ready_i=0; two returns arrive → the first record is held and dropped_o=1. Release ready → the held record drains and rec_v_o returns to 0.
- els_p=16: push 17 requests without returns → overflow_o=1 and count stays 16. With count empty, a return → underflow_o=1 and no record.
- Request from (0,3); return addressed to (0,4) → mismatch_o=1; the record is still emitted with src=(0,3).
- Request at ctr=0xFFFFFFF0, return at ctr=0x00000005 → latency=21. Assert reset with 4 outstanding → rec_v_o=0, count=0, and the next return sets underflow_o.
